// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register, ROM addressing and single-entry IF/ID output buffer
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        target_misaligned;

    assign rom_address       = pc;
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            out_valid        <= 1'b0;
            out_instr        <= 32'h0;
            out_pc           <= 32'h0;
            fetch_misaligned <= 1'b0;
            fetch_count      <= 32'h0;
        end else begin
            // A handshake only counts when the word is not being flushed.
            if (out_valid && out_ready && !redirect_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        pc        <= redirect_pc;
                        if (target_misaligned) begin
                            fetch_misaligned <= 1'b1;
                            state            <= HALT;
                        end else begin
                            fetch_misaligned <= 1'b0;
                        end
                    end else if (!out_valid || out_ready) begin
                        out_instr <= rom_data;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + PC_STEP;
                    end
                end
                HALT: begin
                    out_valid <= 1'b0;
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (!target_misaligned) begin
                            fetch_misaligned <= 1'b0;
                            state            <= FETCH;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized reference-model bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] rom_address, rom_data, out_instr, out_pc, fetch_count;
    logic        out_valid, fetch_misaligned;
    logic [31:0] w_rom_address, w_rom_data, w_out_instr, w_out_pc, w_fetch_count;
    logic        w_out_valid, w_fetch_misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_data   = rom_word(rom_address);
    assign w_rom_data = rom_word(w_rom_address);

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fetch_misaligned(fetch_misaligned), .fetch_count(fetch_count)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .rom_address(w_rom_address), .rom_data(w_rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .fetch_misaligned(w_fetch_misaligned), .fetch_count(w_fetch_count)
    );

    // Reference model: expected fetch address, the buffered word, and counters.
    logic [31:0] m_pc, m_instr, m_opc, m_cnt;
    logic        m_valid, m_mis, m_halt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
        if (!rst) begin
            m_pc = 32'h0; m_valid = 0; m_instr = 0; m_opc = 0;
            m_mis = 0; m_cnt = 0; m_halt = 0;
        end else if (m_halt) begin
            if (rv) begin
                m_pc = rpc;
                if (rpc[1:0] != 0) m_mis = 1;
                else begin m_mis = 0; m_halt = 0; end
            end
        end else if (rv) begin
            m_valid = 0;
            m_pc    = rpc;
            m_mis   = (rpc[1:0] != 0);
            m_halt  = m_mis;
        end else if (!m_valid || rdy) begin
            if (m_valid) m_cnt = m_cnt + 1;
            m_instr = rom_word(m_pc);
            m_opc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 4;
        end
    endtask

    // Drive one cycle's inputs, check the current state, then advance through one edge.
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                         input logic rdy);
        reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        #1;
        chk("rom_address", rom_address, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_pc", out_pc, m_opc);
        chk("out_instr", out_instr, m_instr);
        chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
        chk("fetch_count", fetch_count, m_cnt);
        model_edge(rst, rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        logic        rv, rdy, rst;
        m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_mis = 0; m_cnt = 0; m_halt = 0;
        reset = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 1;
        @(negedge clk);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);

        // Sequential fetch, with the wrapping instance checked alongside.
        cycle(1, 0, 0, 1);
        chk("seq0_pc", out_pc, 32'h0);
        chk("seq0_instr", out_instr, 32'h1000_0000);
        chk("wrap0", w_out_pc, 32'hFFFF_FFF8);
        cycle(1, 0, 0, 1);
        chk("seq1_pc", out_pc, 32'h4);
        chk("wrap1", w_out_pc, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 1);
        chk("seq2_pc", out_pc, 32'h8);
        chk("seq2_instr", out_instr, 32'h1000_0002);
        chk("wrap2", w_out_pc, 32'h0000_0000);
        chk("wrap2_instr", w_out_instr, 32'h1000_0000);

        // Stall at out_pc=8 for three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_cnt", fetch_count, 32'd2);
        end
        cycle(1, 0, 0, 1);
        chk("after_stall_pc", out_pc, 32'hC);

        // Redirect while draining: the buffered word is flushed, not counted.
        cycle(1, 1, 32'h40, 1);
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_cnt", fetch_count, 32'd3);
        cycle(1, 0, 0, 1);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, 32'h1000_0010);

        // Misaligned target halts fetch until an aligned redirect.
        cycle(1, 1, 32'h42, 1);
        for (int i = 0; i < 5; i++) begin
            chk("halt_mis", {31'b0, fetch_misaligned}, 32'h1);
            chk("halt_addr", rom_address, 32'h42);
            cycle(1, 0, 0, 1);
        end
        cycle(1, 1, 32'h20, 1);
        chk("unhalt_mis", {31'b0, fetch_misaligned}, 32'h0);
        cycle(1, 0, 0, 1);
        chk("unhalt_pc", out_pc, 32'h20);

        // Reset in the middle of a stall.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("rst_stall_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_stall_pc", rom_address, 32'h0);
        chk("rst_stall_cnt", fetch_count, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = {$urandom_range(0, 255), 2'b00} << 2;
            if ($urandom_range(0, 4) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle(rst, rv, rpc, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly downstream of the combinational instruction ROM and upstream of decode. Holds the program counter and drives the ROM address. Registers each returned instruction word together with its PC into a single-entry IF/ID output buffer with a valid/ready handshake. Accepts branch/jump redirects from execute, and halts on misaligned redirect targets.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
rom_address  output  32  byte address to ROM; combinational copy of the pc register.
rom_data  input  32  instruction word from ROM, valid in the same cycle as rom_address.
redirect_valid  input  1  execute requests PC change this cycle.
redirect_pc  input  32  redirect target byte address.
out_valid  output  1  out_instr/out_pc hold a fetched instruction.
out_ready  input  1  decode accepts the output this cycle.
out_instr  output  32  registered instruction word.
out_pc  output  32  registered PC of out_instr.
fetch_misaligned  output  1  sticky flag: last redirect target had a nonzero value in bits [1:0].
fetch_count  output  32  number of completed output handshakes (out_valid && out_ready).

Behaviour:
- Reset (reset==0 at posedge):
  - pc<=RESET_PC; state<=FETCH.
  - out_valid<=0, out_instr<=0, out_pc<=0.
  - fetch_misaligned<=0, fetch_count<=0.
  - Reset overrides every other input, including mid-redirect and mid-stall.
- rom_address = pc at all times, including during reset and HALT.
- States: FETCH, HALT.
- FETCH, priority order per posedge:
  1. redirect_valid=1:
     - out_valid<=0, flushing any buffered word even if out_ready=1 this cycle.
     - pc<=redirect_pc.
     - If redirect_pc[1:0]!=0: fetch_misaligned<=1 and state<=HALT.
     - Otherwise: fetch_misaligned<=0.
  2. Otherwise, if out_valid==0 or out_ready==1 (buffer empty or draining): out_instr<=rom_data, out_pc<=pc, out_valid<=1, pc<=pc+PC_STEP.
  3. Otherwise (stall, out_valid=1 and out_ready=0): pc, out_instr, out_pc and out_valid are held; outputs stay stable.
- HALT:
  - out_valid=0 and pc is held.
  - An aligned redirect loads pc, clears fetch_misaligned and sets state<=FETCH.
  - A misaligned redirect loads pc and stays in HALT.
- Latency:
  - Instruction at pc appears on out_* at the edge after pc is presented.
  - After redirect asserted in cycle N: pc=target in N+1, out_valid=1 with out_pc=target in N+2.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- fetch_count:
  - Increments by 1 on any posedge with out_valid=1, out_ready=1 and redirect_valid=0.
  - A flushed word does not count.
  - Wraps modulo 2^32.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag. The ROM address decode aliasing is the ROM's concern, not this block's.
- The no-combinational-path rule applies to out_valid only; out_ready may depend on nothing from this block combinationally.
- The ROM is read every cycle, even when stalled; the result is discarded when not captured.

Test Plan:
- Reset/sequential: bench ROM returns 32'h10000000+(addr>>2); hold reset=0 for 2 cycles, then release with out_ready=1 -> out_valid=0 during reset; then out_pc=0,4,8,12 with out_instr=32'h10000000,32'h10000001,32'h10000002,32'h10000003 on consecutive cycles; fetch_count increments each cycle.
- Stall: drop out_ready for 3 cycles while out_pc=8 -> out_pc=8 and out_instr=32'h10000002 held stable; fetch_count frozen; after release next out_pc=12, with no skip and no duplicate.
- Redirect: assert redirect_valid with redirect_pc=32'h40 while out_valid=1 and out_ready=1 -> next cycle out_valid=0 and fetch_count unchanged; following cycle out_pc=32'h40, out_instr=32'h10000010.
- Misaligned: redirect_pc=32'h42 -> fetch_misaligned=1 and out_valid stays 0 for 5 cycles with rom_address=32'h42; then aligned redirect to 32'h20 -> flag clears and out_pc=32'h20 two cycles after the redirect.
- Wrap: RESET_PC=32'hFFFFFFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- Reset mid-stall: assert reset=0 while out_valid=1 and out_ready=0 -> next edge out_valid=0, pc=RESET_PC, fetch_count=0.
